// File: rtl/nco_multi_if.sv
// Config write port of nco_multi: channel/select/data, qualified by a valid/ready handshake.
// Latency: none; this is a plain signal bundle.
// Backpressure: a write transfers only in a cycle where cfg_valid_in and cfg_ready_out are both high.
//
// Signals:
//   cfg_valid_in  - write request from the configuring agent
//   cfg_ready_out - oscillator can accept a write this cycle
//   cfg_ch_in     - target channel
//   cfg_sel_in    - 0 selects the FCW shadow, 1 selects the offset shadow
//   cfg_data_in   - value to write
// Modports: master = configuring agent, slave = nco_multi.
interface nco_multi_if #(
    parameter int CH_BITS  = 2,
    parameter int ACC_BITS = 24
);
    logic                cfg_valid_in;
    logic                cfg_ready_out;
    logic [CH_BITS-1:0]  cfg_ch_in;
    logic                cfg_sel_in;
    logic [ACC_BITS-1:0] cfg_data_in;

    modport master (
        output cfg_valid_in,
        output cfg_ch_in,
        output cfg_sel_in,
        output cfg_data_in,
        input  cfg_ready_out
    );

    modport slave (
        input  cfg_valid_in,
        input  cfg_ch_in,
        input  cfg_sel_in,
        input  cfg_data_in,
        output cfg_ready_out
    );
endinterface

// File: rtl/nco_multi.sv
// Multi-channel NCO: per-channel phase accumulators, shadowed FCW/offset, truncated phase out.
// Latency: 2 edges from en_in to phase_out (accumulator update, then output register).
// Backpressure: cfg_ready_out drops for exactly the cycle after each commit; never stalls the datapath.
//
// Ports:
//   clk_in, rst_n_in - clock (rising edge) and asynchronous active-low reset
//   en_in            - advance every accumulator by its active FCW this cycle
//   commit_in        - copy all shadow FCW/offset registers to the active set at once
//   phase_clr_in     - synchronous clear of all accumulators (wins over en_in)
//   cfg              - config write port (nco_multi_if.slave)
//   phase_out        - channel c at [c*OUT_BITS +: OUT_BITS]
//   wrap_out         - per-channel one-cycle carry-out pulse, aligned with phase_out
//   valid_out        - phase_out holds a new sample (en_in delayed by two edges)
//
// Build option: define NCO_DITHER_EN to add a shared 16-bit LFSR dither ahead of the
// truncation (requires ACC_BITS > OUT_BITS). Without it the output is pure truncation.
module nco_multi #(
    parameter int CH_BITS  = 2,
    parameter int ACC_BITS = 24,
    parameter int OUT_BITS = 10
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic                                en_in,
    input  logic                                commit_in,
    input  logic                                phase_clr_in,
    nco_multi_if.slave                          cfg,
    output logic [(2**CH_BITS)*OUT_BITS-1:0]    phase_out,
    output logic [(2**CH_BITS)-1:0]             wrap_out,
    output logic                                valid_out
);

    localparam int NUM_CH = 2**CH_BITS;
    localparam int SHIFT  = ACC_BITS - OUT_BITS;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_BITS-1:0]        r_acc     [NUM_CH];
    logic [ACC_BITS-1:0]        r_fcw_act [NUM_CH];
    logic [ACC_BITS-1:0]        r_off_act [NUM_CH];
    logic [ACC_BITS-1:0]        r_fcw_sh  [NUM_CH];
    logic [ACC_BITS-1:0]        r_off_sh  [NUM_CH];
    logic [NUM_CH-1:0]          r_carry;
    logic [NUM_CH-1:0]          r_wrap;
    logic [NUM_CH*OUT_BITS-1:0] r_phase_out;
    logic                       r_en_d;
    logic                       r_valid;
    logic                       r_cfg_rdy;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                       w_wr;
    logic [ACC_BITS-1:0]        w_fcw_fwd [NUM_CH];
    logic [ACC_BITS-1:0]        w_off_fwd [NUM_CH];
    logic [ACC_BITS:0]          w_inc     [NUM_CH];
    logic [OUT_BITS-1:0]        w_phase   [NUM_CH];

    assign w_wr              = cfg.cfg_valid_in && r_cfg_rdy;
    assign cfg.cfg_ready_out = r_cfg_rdy;

`ifdef NCO_DITHER_EN
    // Dither width: only the bits that truncation discards, capped at the LFSR width.
    localparam int DITH_W = (SHIFT > 16) ? 16 : SHIFT;

    logic [15:0]         r_lfsr;
    logic [ACC_BITS-1:0] w_dith;

    assign w_dith = ACC_BITS'(r_lfsr[DITH_W-1:0]);

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; one step per enabled sample so the
    // dither sequence tracks the sample stream, shared by all channels.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_lfsr <= 16'hACE1;
        end else if (en_in) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // Shadow value as it will be after this edge: a write accepted in the
            // commit cycle is forwarded straight into the active register.
            w_fcw_fwd[c] = r_fcw_sh[c];
            w_off_fwd[c] = r_off_sh[c];
            if (w_wr && (cfg.cfg_ch_in == CH_BITS'(c))) begin
                if (cfg.cfg_sel_in) begin
                    w_off_fwd[c] = cfg.cfg_data_in;
                end else begin
                    w_fcw_fwd[c] = cfg.cfg_data_in;
                end
            end

            // One extra bit captures the carry-out used for the wrap pulse.
            w_inc[c] = {1'b0, r_acc[c]} + {1'b0, r_fcw_act[c]};

            // Offset add is modulo 2**ACC_BITS (self-determined width), then the
            // top OUT_BITS are kept.
`ifdef NCO_DITHER_EN
            w_phase[c] = OUT_BITS'((r_acc[c] + r_off_act[c] + w_dith) >> SHIFT);
`else
            w_phase[c] = OUT_BITS'((r_acc[c] + r_off_act[c]) >> SHIFT);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Config: shadows, active registers, ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_fcw_sh[c]  <= '0;
                r_off_sh[c]  <= '0;
                r_fcw_act[c] <= '0;
                r_off_act[c] <= '0;
            end
            r_cfg_rdy <= 1'b1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_fcw_sh[c] <= w_fcw_fwd[c];
                r_off_sh[c] <= w_off_fwd[c];
                // All channels switch on the same edge, so retuning is phase-coherent.
                if (commit_in) begin
                    r_fcw_act[c] <= w_fcw_fwd[c];
                    r_off_act[c] <= w_off_fwd[c];
                end
            end
            // Hold off writes for the cycle after a commit; back-to-back commits
            // keep the port closed.
            r_cfg_rdy <= !commit_in;
        end
    end

    // ------------------------------------------------------------------
    // Phase accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c] <= '0;
            end
            r_carry <= '0;
            r_en_d  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (phase_clr_in) begin
                    // A clear is not a wrap: no carry recorded.
                    r_acc[c]   <= '0;
                    r_carry[c] <= 1'b0;
                end else if (en_in) begin
                    // Uses the active FCW held at this edge; a commit on the same
                    // edge only affects the next increment.
                    r_acc[c]   <= w_inc[c][ACC_BITS-1:0];
                    r_carry[c] <= w_inc[c][ACC_BITS];
                end else begin
                    r_carry[c] <= 1'b0;
                end
            end
            r_en_d <= en_in;
        end
    end

    // ------------------------------------------------------------------
    // Output register: runs every cycle so offset commits reach phase_out
    // even while en_in is low. Carry and valid are delayed one more edge to
    // line up with the phase derived from the updated accumulator.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_phase_out <= '0;
            r_wrap      <= '0;
            r_valid     <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_phase_out[c*OUT_BITS +: OUT_BITS] <= w_phase[c];
            end
            r_wrap  <= r_carry;
            r_valid <= r_en_d;
        end
    end

    assign phase_out = r_phase_out;
    assign wrap_out  = r_wrap;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_nco_multi.sv
// Bench for nco_multi: directed stimulus, scoreboard of expected samples drained by a monitor.
// Latency: expected samples are queued on the en_in edge and consumed two edges later.
// Backpressure: bench tracks cfg_ready_out itself so only handshaken writes reach the model.
module tb_nco_multi;

    localparam int CHB = 2;
    localparam int AB  = 24;
    localparam int OB  = 10;
    localparam int NCH = 4;

    logic              clk_in       = 1'b0;
    logic              rst_n_in     = 1'b0;
    logic              en_in        = 1'b0;
    logic              commit_in    = 1'b0;
    logic              phase_clr_in = 1'b0;
    logic [NCH*OB-1:0] phase_out;
    logic [NCH-1:0]    wrap_out;
    logic              valid_out;

    nco_multi_if #(.CH_BITS(CHB), .ACC_BITS(AB)) cfg_if ();

    nco_multi #(.CH_BITS(CHB), .ACC_BITS(AB), .OUT_BITS(OB)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .en_in        (en_in),
        .commit_in    (commit_in),
        .phase_clr_in (phase_clr_in),
        .cfg          (cfg_if),
        .phase_out    (phase_out),
        .wrap_out     (wrap_out),
        .valid_out    (valid_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests   = 0;
    int n_fail    = 0;
    int wrap0_cnt = 0;

    typedef struct packed {
        logic [NCH*OB-1:0] ph;
        logic [NCH-1:0]    wr;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    // Behavioural reference state
    logic [AB-1:0] m_acc [NCH];
    logic [AB-1:0] m_fa  [NCH];
    logic [AB-1:0] m_oa  [NCH];
    logic [AB-1:0] m_fs  [NCH];
    logic [AB-1:0] m_os  [NCH];
    logic          m_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*OB-1:0] m_phase();
        logic [NCH*OB-1:0] v;
        logic [AB-1:0]     s;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            s = m_acc[c] + m_oa[c];
            v[c*OB +: OB] = s[AB-1 -: OB];
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = '0; m_fa[c] = '0; m_oa[c] = '0; m_fs[c] = '0; m_os[c] = '0;
        end
        m_rdy = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the reference at the edge, queue the
    // expected sample when the cycle is enabled, then return inputs to idle.
    task automatic step(input logic en, input logic clr, input logic com, input logic cv,
                        input logic [CHB-1:0] ch, input logic sel, input logic [AB-1:0] d);
        logic          wr;
        logic [AB:0]   t;
        logic [NCH-1:0] cy;
        logic [AB-1:0] ff [NCH];
        logic [AB-1:0] of [NCH];
        exp_t          e;
        en_in               = en;
        phase_clr_in        = clr;
        commit_in           = com;
        cfg_if.cfg_valid_in = cv;
        cfg_if.cfg_ch_in    = ch;
        cfg_if.cfg_sel_in   = sel;
        cfg_if.cfg_data_in  = d;
        @(posedge clk_in);
        wr = cv && m_rdy;
        cy = '0;
        for (int c = 0; c < NCH; c++) begin
            ff[c] = m_fs[c];
            of[c] = m_os[c];
            if (wr && (ch == CHB'(c))) begin
                if (sel) of[c] = d;
                else     ff[c] = d;
            end
            if (clr) begin
                m_acc[c] = '0;
            end else if (en) begin
                t        = {1'b0, m_acc[c]} + {1'b0, m_fa[c]};
                cy[c]    = t[AB];
                m_acc[c] = t[AB-1:0];
            end
            m_fs[c] = ff[c];
            m_os[c] = of[c];
            if (com) begin
                m_fa[c] = ff[c];
                m_oa[c] = of[c];
            end
        end
        m_rdy = !com;
        if (en) begin
            e.ph = m_phase();
            e.wr = cy;
            sb.push_back(e);
        end
        #1;
        en_in               = 1'b0;
        phase_clr_in        = 1'b0;
        commit_in           = 1'b0;
        cfg_if.cfg_valid_in = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // Monitor: every presented sample is checked against the oldest queued expectation.
    always @(negedge clk_in) begin
        if (rst_n_in && valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got a sample, expected none queued");
            end else begin
                m_e = sb.pop_front();
                chk("sample_phase", 64'(phase_out), 64'(m_e.ph));
                chk("sample_wrap", 64'(wrap_out), 64'(m_e.wr));
                if (wrap_out[0]) wrap0_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        cfg_if.cfg_valid_in = 1'b0;
        cfg_if.cfg_ch_in    = '0;
        cfg_if.cfg_sel_in   = 1'b0;
        cfg_if.cfg_data_in  = '0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_phase", 64'(phase_out), 64'h0);
        chk("rst_wrap", 64'(wrap_out), 64'h0);
        chk("rst_valid", 64'(valid_out), 64'h0);
        chk("rst_ready", 64'(cfg_if.cfg_ready_out), 64'h1);
        rst_n_in = 1'b1;

        // ch0 FCW 0x040000: +0x010 per sample, one wrap per 64 samples
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 24'h040000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'h0);
        chk("ready_after_commit", 64'(cfg_if.cfg_ready_out), 64'h0);
        idle();
        chk("ready_recovered", 64'(cfg_if.cfg_ready_out), 64'h1);
        run(70);
        idle();
        chk("ch0_after_70", 64'(phase_out[9:0]), 64'h060);
        chk("ch0_wrap_count", 64'(wrap0_cnt), 64'd1);

        // ch1 offset 0x800000, FCW 0, en low: 0x200 two edges after commit
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 24'h800000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'h0);
        chk("ch1_one_edge", 64'(phase_out[19:10]), 64'h000);
        idle();
        chk("ch1_two_edges", 64'(phase_out[19:10]), 64'h200);

        // ch2: uncommitted FCW has no effect; write forwarded in the commit cycle
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 24'h200000);
        run(3);
        idle();
        chk("ch2_uncommitted", 64'(phase_out[29:20]), 64'h000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 24'h100000);
        chk("ready_commit_fwd", 64'(cfg_if.cfg_ready_out), 64'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'h0);
        chk("ready_b2b_commit", 64'(cfg_if.cfg_ready_out), 64'h0);
        idle();
        chk("ready_after_b2b", 64'(cfg_if.cfg_ready_out), 64'h1);
        run(3);
        idle();
        chk("ch2_three_steps", 64'(phase_out[29:20]), 64'h0C0);

        // phase clear with en: samples restart from 0, no wrap
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
        run(1);
        idle();
        chk("ch0_after_clr", 64'(phase_out[9:0]), 64'h010);
        chk("ch2_after_clr", 64'(phase_out[29:20]), 64'h040);

        // clear + commit on one edge: first increment uses the new FCW
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 24'h080000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 24'h0);
        run(2);
        idle();
        chk("ch0_clr_commit", 64'(phase_out[9:0]), 64'h040);

        // asynchronous reset mid-run
        run(5);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("midrst_phase", 64'(phase_out), 64'h0);
        chk("midrst_wrap", 64'(wrap_out), 64'h0);
        chk("midrst_valid", 64'(valid_out), 64'h0);
        chk("midrst_ready", 64'(cfg_if.cfg_ready_out), 64'h1);
        sb.delete();
        model_reset();
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        run(4);
        idle();
        chk("post_rst_phase", 64'(phase_out), 64'h0);
        chk("post_rst_ready", 64'(cfg_if.cfg_ready_out), 64'h1);

        idle();
        idle();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
